// File: rtl/store_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_unit
// Description : MEM-stage store path. Aligns SB/SH/SW data to the word lanes,
//               generates byte strobes and issues one or two valid/ready write
//               beats to data memory, stalling MEM until the store completes.
// Revision    : 1.0 - initial release
// ============================================================================
module store_unit #(
  parameter logic MISALIGNED_SPLIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StoreReqM,
  input  logic [1:0]  StoreControlM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic        StoreDoneM,
  output logic        StoreErr,
  output logic        MemValid,
  input  logic        MemReady,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemWStrb
);

  typedef enum logic [1:0] {
    c_IDLE  = 2'd0,
    c_BEAT0 = 2'd1,
    c_BEAT1 = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_need2;
  logic [3:0]  r_hiStrb;
  logic [31:0] r_hiData;

  logic [3:0]  w_mask;
  logic [31:0] w_data;
  logic [7:0]  w_s8;
  logic [63:0] w_d64;
  logic        w_need2;
  logic        w_illegal;
  logic        w_accept;
  logic        w_handshake;

  // Byte mask and zero-extended store data selected by the access size
  always_comb begin
    w_mask = 4'b0000;
    w_data = 32'd0;
    case (StoreControlM)
      2'b00: begin
        w_mask = 4'b0001;
        w_data = {24'd0, WriteDataM[7:0]};
      end
      2'b01: begin
        w_mask = 4'b0011;
        w_data = {16'd0, WriteDataM[15:0]};
      end
      2'b10: begin
        w_mask = 4'b1111;
        w_data = WriteDataM;
      end
      default: begin
        w_mask = 4'b0000;
        w_data = 32'd0;
      end
    endcase
  end

  // Strobes and data spread across two consecutive words; upper half is the
  // part that spills past the word boundary.
  assign w_s8        = {4'b0000, w_mask} << AddrM[1:0];
  assign w_d64       = {32'd0, w_data} << {AddrM[1:0], 3'b000};
  assign w_need2     = |w_s8[7:4];
  assign w_illegal   = (StoreControlM == 2'b11) | (w_need2 & ~MISALIGNED_SPLIT);
  assign w_accept    = (r_state == c_IDLE) & StoreReqM & ~w_illegal;
  assign w_handshake = MemValid & MemReady;

  assign StoreDoneM  = w_handshake &
                       (((r_state == c_BEAT0) & ~r_need2) | (r_state == c_BEAT1));
  // Drops in the final handshake cycle so the pipeline advances on that edge
  assign StallM      = w_accept | ((r_state != c_IDLE) & ~StoreDoneM);

  // Store FSM with registered bus outputs; beat fields hold while waiting on MemReady
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_need2  <= 1'b0;
      r_hiStrb <= 4'b0000;
      r_hiData <= 32'd0;
      MemValid <= 1'b0;
      MemAddr  <= 32'd0;
      MemWData <= 32'd0;
      MemWStrb <= 4'b0000;
      StoreErr <= 1'b0;
    end else begin
      StoreErr <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (StoreReqM && w_illegal) begin
            StoreErr <= 1'b1;
          end else if (w_accept) begin
            r_state  <= c_BEAT0;
            r_need2  <= w_need2;
            r_hiStrb <= w_s8[7:4];
            r_hiData <= w_d64[63:32];
            MemValid <= 1'b1;
            MemAddr  <= {AddrM[31:2], 2'b00};
            MemWStrb <= w_s8[3:0];
            MemWData <= w_d64[31:0];
          end
        end
        c_BEAT0: begin
          if (w_handshake) begin
            if (r_need2) begin
              r_state  <= c_BEAT1;
              MemAddr  <= MemAddr + 32'd4;
              MemWStrb <= r_hiStrb;
              MemWData <= r_hiData;
            end else begin
              r_state  <= c_IDLE;
              MemValid <= 1'b0;
            end
          end
        end
        c_BEAT1: begin
          if (w_handshake) begin
            r_state  <= c_IDLE;
            MemValid <= 1'b0;
          end
        end
        default: begin
          r_state  <= c_IDLE;
          MemValid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_unit
// Description : Directed self-checking bench for store_unit (split and
//               no-split builds driven from the same stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_unit;

  logic        clk;
  logic        rst_n;
  logic        StoreReqM;
  logic [1:0]  StoreControlM;
  logic [31:0] AddrM;
  logic [31:0] WriteDataM;
  logic        MemReady;

  logic        StallM, StoreDoneM, StoreErr, MemValid;
  logic [31:0] MemAddr, MemWData;
  logic [3:0]  MemWStrb;

  logic        ns_StallM, ns_StoreDoneM, ns_StoreErr, ns_MemValid;
  logic [31:0] ns_MemAddr, ns_MemWData;
  logic [3:0]  ns_MemWStrb;

  int nChecks = 0;
  int nBad    = 0;

  store_unit #(.MISALIGNED_SPLIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .StoreReqM(StoreReqM), .StoreControlM(StoreControlM),
    .AddrM(AddrM), .WriteDataM(WriteDataM), .StallM(StallM), .StoreDoneM(StoreDoneM),
    .StoreErr(StoreErr), .MemValid(MemValid), .MemReady(MemReady), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemWStrb(MemWStrb)
  );

  store_unit #(.MISALIGNED_SPLIT(1'b0)) dutNoSplit (
    .clk(clk), .rst_n(rst_n), .StoreReqM(StoreReqM), .StoreControlM(StoreControlM),
    .AddrM(AddrM), .WriteDataM(WriteDataM), .StallM(ns_StallM), .StoreDoneM(ns_StoreDoneM),
    .StoreErr(ns_StoreErr), .MemValid(ns_MemValid), .MemReady(MemReady), .MemAddr(ns_MemAddr),
    .MemWData(ns_MemWData), .MemWStrb(ns_MemWStrb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One beat observed at a negedge: bus fields plus handshake outputs
  task automatic checkBeat(input string tag, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic done, input logic stall);
    chk({tag, ".valid"}, {31'd0, MemValid}, 32'd1);
    chk({tag, ".addr"}, MemAddr, a);
    chk({tag, ".strb"}, {28'd0, MemWStrb}, {28'd0, s});
    chk({tag, ".wdata"}, MemWData, d);
    chk({tag, ".done"}, {31'd0, StoreDoneM}, {31'd0, done});
    chk({tag, ".stall"}, {31'd0, StallM}, {31'd0, stall});
  endtask

  // Present a request just after a rising edge and confirm it stalls without a beat yet
  task automatic issue(input string tag, input logic [1:0] ctrl, input logic [31:0] addr,
                       input logic [31:0] data);
    @(posedge clk); #1;
    StoreReqM     = 1'b1;
    StoreControlM = ctrl;
    AddrM         = addr;
    WriteDataM    = data;
    @(negedge clk);
    chk({tag, ".reqStall"}, {31'd0, StallM}, 32'd1);
    chk({tag, ".reqNoBeat"}, {31'd0, MemValid}, 32'd0);
  endtask

  task automatic dropReq();
    @(posedge clk); #1;
    StoreReqM = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; StoreReqM = 1'b0; StoreControlM = 2'b00;
    AddrM = 32'd0; WriteDataM = 32'd0; MemReady = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.valid", {31'd0, MemValid}, 32'd0);
    chk("rst.addr", MemAddr, 32'd0);
    chk("rst.wdata", MemWData, 32'd0);
    chk("rst.strb", {28'd0, MemWStrb}, 32'd0);
    chk("rst.err", {31'd0, StoreErr}, 32'd0);
    chk("rst.done", {31'd0, StoreDoneM}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Aligned SW, single beat, done in cycle N+1
    issue("sw", 2'b10, 32'h0000_0100, 32'hDEAD_BEEF);
    @(negedge clk);
    checkBeat("sw.b0", 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 1'b1, 1'b0);
    dropReq();
    @(negedge clk);
    chk("sw.idle", {31'd0, MemValid}, 32'd0);
    chk("sw.noStall", {31'd0, StallM}, 32'd0);

    // SB at top byte lane
    issue("sb", 2'b00, 32'h0000_0203, 32'h1234_56AB);
    @(negedge clk);
    checkBeat("sb.b0", 32'h0000_0200, 4'b1000, 32'hAB00_0000, 1'b1, 1'b0);
    // Back-to-back: next request presented the cycle after done
    @(posedge clk); #1;
    StoreControlM = 2'b01; AddrM = 32'h0000_0202; WriteDataM = 32'h1234_CAFE;
    @(negedge clk);
    chk("sh.reqStall", {31'd0, StallM}, 32'd1);
    @(negedge clk);
    checkBeat("sh.b0", 32'h0000_0200, 4'b1100, 32'hCAFE_0000, 1'b1, 1'b0);
    dropReq();

    // Misaligned SW split across two words
    issue("swSplit", 2'b10, 32'h0000_0301, 32'h1122_3344);
    @(negedge clk);
    checkBeat("swSplit.b0", 32'h0000_0300, 4'b1110, 32'h2233_4400, 1'b0, 1'b1);
    @(negedge clk);
    checkBeat("swSplit.b1", 32'h0000_0304, 4'b0001, 32'h0000_0011, 1'b1, 1'b0);
    dropReq();

    // SH at the top of the address space: second beat wraps to 0
    issue("shWrap", 2'b01, 32'hFFFF_FFFF, 32'h0000_BEEF);
    @(negedge clk);
    checkBeat("shWrap.b0", 32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000, 1'b0, 1'b1);
    @(negedge clk);
    checkBeat("shWrap.b1", 32'h0000_0000, 4'b0001, 32'h0000_00BE, 1'b1, 1'b0);
    dropReq();

    // Wait states: MemReady low for three beat cycles
    MemReady = 1'b0;
    issue("swWait", 2'b10, 32'h0000_0400, 32'h0BAD_F00D);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkBeat($sformatf("swWait.hold%0d", i), 32'h0000_0400, 4'b1111, 32'h0BAD_F00D, 1'b0, 1'b1);
    end
    @(posedge clk); #1; MemReady = 1'b1;
    @(negedge clk);
    checkBeat("swWait.done", 32'h0000_0400, 4'b1111, 32'h0BAD_F00D, 1'b1, 1'b0);
    dropReq();

    // Illegal control code: error pulse, no stall, no beat
    @(posedge clk); #1;
    StoreReqM = 1'b1; StoreControlM = 2'b11; AddrM = 32'h0000_0500; WriteDataM = 32'h5555_5555;
    @(negedge clk);
    chk("ill.noStall", {31'd0, StallM}, 32'd0);
    dropReq();
    @(negedge clk);
    chk("ill.err", {31'd0, StoreErr}, 32'd1);
    chk("ill.noBeat", {31'd0, MemValid}, 32'd0);
    @(negedge clk);
    chk("ill.errPulse", {31'd0, StoreErr}, 32'd0);

    // Word-crossing SW on the no-split build: error, while split build proceeds
    @(posedge clk); #1;
    StoreReqM = 1'b1; StoreControlM = 2'b10; AddrM = 32'h0000_0002; WriteDataM = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("ns.noStall", {31'd0, ns_StallM}, 32'd0);
    chk("sp.stall", {31'd0, StallM}, 32'd1);
    dropReq();
    @(negedge clk);
    chk("ns.err", {31'd0, ns_StoreErr}, 32'd1);
    chk("ns.noBeat", {31'd0, ns_MemValid}, 32'd0);
    chk("sp.noErr", {31'd0, StoreErr}, 32'd0);
    @(negedge clk);
    chk("ns.errPulse", {31'd0, ns_StoreErr}, 32'd0);
    repeat (2) @(posedge clk);

    // Reset asserted while in BEAT1
    issue("rstMid", 2'b10, 32'h0000_0301, 32'h1122_3344);
    @(negedge clk);
    checkBeat("rstMid.b0", 32'h0000_0300, 4'b1110, 32'h2233_4400, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0; StoreReqM = 1'b0; MemReady = 1'b0;
    @(negedge clk);
    chk("rstMid.inBeat1", MemAddr, 32'h0000_0304);
    @(negedge clk);
    chk("rstMid.valid", {31'd0, MemValid}, 32'd0);
    chk("rstMid.addr", MemAddr, 32'd0);
    chk("rstMid.wdata", MemWData, 32'd0);
    chk("rstMid.strb", {28'd0, MemWStrb}, 32'd0);
    chk("rstMid.done", {31'd0, StoreDoneM}, 32'd0);
    chk("rstMid.stall", {31'd0, StallM}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1; MemReady = 1'b1;

    // Post-reset store works from IDLE
    issue("post", 2'b00, 32'h0000_0601, 32'hFFFF_FF5A);
    @(negedge clk);
    checkBeat("post.b0", 32'h0000_0600, 4'b0010, 32'h0000_5A00, 1'b1, 1'b0);
    dropReq();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
`default_nettype wire
